dmem_ctrl: RTL

Parametrised data-memory controller for the pipelined MIPS core, replacing the direct single-cycle hookup of the data RAM. It owns a word-organised RAM of configurable depth, supports byte/halfword/word stores through byte-lane enables, and byte/halfword loads with sign or zero extension. Each access takes a configurable number of wait states and holds the pipeline through a combinational `stall`. Misaligned and out-of-range accesses are flagged and do not touch memory.

---
 rtl/dmem_ctrl_if.sv | 23 ++
 rtl/dmem_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the MEM pipeline stage and the data-memory controller.
interface dmem_ctrl_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        done;
  logic        err;

  modport master (
    output req, we, size, sign_ext, addr, wdata,
    input  rdata, stall, done, err
  );

  modport slave (
    input  req, we, size, sign_ext, addr, wdata,
    output rdata, stall, done, err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: word RAM with byte-lane stores, extending loads,
// configurable wait states and a combinational pipeline stall.
module dmem_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  dmem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;

  logic        l_we, l_sext;
  logic [1:0]  l_size;
  logic [31:0] l_addr, l_wdata;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [2**ADDR_W];

  // In IDLE the access is taken straight from the bus so that a zero-wait
  // access can commit on the same edge that leaves IDLE.
  logic        a_we, a_sext, a_err, commit;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wdata;
  logic [ADDR_W-1:0] a_idx;
  logic [31:0] word_q, load_val, wr_data;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [3:0]  be;

  assign a_we    = (state == S_IDLE) ? bus.we       : l_we;
  assign a_sext  = (state == S_IDLE) ? bus.sign_ext : l_sext;
  assign a_size  = (state == S_IDLE) ? bus.size     : l_size;
  assign a_addr  = (state == S_IDLE) ? bus.addr     : l_addr;
  assign a_wdata = (state == S_IDLE) ? bus.wdata    : l_wdata;
  assign a_idx   = a_addr[ADDR_W+1:2];

  assign a_err = (a_size == 2'b11)
              || (a_size == 2'b01 && a_addr[0])
              || (a_size == 2'b10 && a_addr[1:0] != 2'b00)
              || ((a_addr >> (ADDR_W + 2)) != 32'd0);

  // Gating with rst keeps an access from committing while reset is held.
  assign commit = rst && (state_nxt == S_RESP) && (state != S_RESP);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statement can leave it unassigned and infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: if (bus.req) begin
        cnt_nxt   = WAIT_INIT;
        state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = S_RESP;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    word_q = mem[a_idx];
    byte_v = word_q[{a_addr[1:0], 3'b000} +: 8];
    half_v = a_addr[1] ? word_q[31:16] : word_q[15:0];
    case (a_size)
      2'b00:   load_val = {{24{a_sext & byte_v[7]}}, byte_v};
      2'b01:   load_val = {{16{a_sext & half_v[15]}}, half_v};
      default: load_val = word_q;
    endcase
  end

  always_comb begin
    be      = 4'b0000;
    wr_data = a_wdata;
    case (a_size)
      2'b00: begin
        be      = 4'b0001 << a_addr[1:0];
        wr_data = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        be      = a_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{a_wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      l_we    <= 1'b0;
      l_sext  <= 1'b0;
      l_size  <= 2'b00;
      l_addr  <= 32'd0;
      l_wdata <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == S_IDLE && bus.req) begin
        l_we    <= bus.we;
        l_sext  <= bus.sign_ext;
        l_size  <= bus.size;
        l_addr  <= bus.addr;
        l_wdata <= bus.wdata;
      end
      if (commit) begin
        err_q   <= a_err;
        rdata_q <= (a_err || a_we) ? 32'd0 : load_val;
      end
    end
  end

  // NOTE: the RAM array has no reset; its contents are undefined until written.
  always_ff @(posedge clk) begin
    if (commit && a_we && !a_err) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[a_idx][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  assign bus.stall = (state == S_IDLE && bus.req) || (state == S_WAIT);
  assign bus.done  = (state == S_RESP);
  assign bus.err   = (state == S_RESP) && err_q;
  assign bus.rdata = rdata_q;

endmodule
